// File: rtl/sort_loader_pkg.sv
// rtl/sort_loader_pkg.sv - shared sort types: frame FSM states and pad value helper
package sort_loader_pkg;

    // Frame loader states: collecting elements, or presenting a complete frame
    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_e;

    localparam int PAD_MAX_W = 64;

    // All-ones pad of the given width (callers truncate to their element width).
    // Pads sort to the top, so real elements always stay in the low slots.
    function automatic logic [PAD_MAX_W-1:0] pad_value(input int w);
        return {PAD_MAX_W{1'b1}} >> (PAD_MAX_W - w);
    endfunction

endpackage

// File: rtl/sort_loader.sv
// rtl/sort_loader.sv - serial-to-frame loader feeding the sort network
module sort_loader
    import sort_loader_pkg::*;
#(
    parameter int width = 8,
    parameter int index = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [width-1:0]           in_data,
    output logic                       in_ready,
    input  logic                       flush,
    output logic [width-1:0]           frame_data [0:index-1],
    output logic                       frame_valid,
    input  logic                       frame_ready,
    output logic [$clog2(index+1)-1:0] frame_fill
);

    localparam int CW = $clog2(index);
    localparam int FW = $clog2(index+1);
    localparam logic [width-1:0] PAD  = width'(pad_value(width));
    localparam logic [CW-1:0]    LAST = CW'(index-1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [FW-1:0]   fill_q, fill_d;
    logic            xfer;
    logic            do_flush;
    logic            to_full;

    assign in_ready    = (state_q == FILL);
    assign frame_valid = (state_q == FULL);
    assign frame_fill  = fill_q;

    assign xfer     = in_valid && in_ready;
    // A flush only closes a frame that will hold at least one real element
    assign do_flush = flush && in_ready && (xfer || (cnt_q != '0));
    assign to_full  = (xfer && (cnt_q == LAST)) || do_flush;

    // Next-state decode; entering FULL replaces the counter increment so cnt never wraps
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fill_d  = fill_q;
        case (state_q)
            FILL: begin
                if (to_full) begin
                    state_d = FULL;
                    cnt_d   = '0;
                    fill_d  = xfer ? (FW'(cnt_q) + FW'(1)) : FW'(cnt_q);
                end else if (xfer) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FULL: begin
                if (frame_ready) begin
                    state_d = FILL;
                    cnt_d   = '0;
                    fill_d  = '0;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // State, write counter and fill count registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FILL;
            cnt_q   <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
        end
    end

    for (genvar i = 0; i < index; i++) begin : g_slot
        logic [width-1:0] slot_q;
        logic             wr_en;
        logic             pad_en;

        assign wr_en  = xfer && (cnt_q == CW'(i));
        // Pad every slot above the last real element written this cycle
        assign pad_en = do_flush && ((cnt_q < CW'(i)) || (!xfer && (cnt_q == CW'(i))));

        // Slot storage: real element takes priority over pad; otherwise hold
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                slot_q <= '0;
            end else if (wr_en) begin
                slot_q <= in_data;
            end else if (pad_en) begin
                slot_q <= PAD;
            end
        end

        assign frame_data[i] = slot_q;
    end

endmodule

// File: tb/tb_sort_loader.sv
// tb/tb_sort_loader.sv - scoreboard bench for sort_loader
module tb_sort_loader;

    localparam int W = 8;
    localparam int N = 8;

    typedef struct {
        logic [W-1:0] d [N];
        int           fill;
    } frame_t;

    logic                   clk;
    logic                   rst;
    logic                   in_valid;
    logic [W-1:0]           in_data;
    logic                   in_ready;
    logic                   flush;
    logic [W-1:0]           frame_data [0:N-1];
    logic                   frame_valid;
    logic                   frame_ready;
    logic [$clog2(N+1)-1:0] frame_fill;

    sort_loader #(.width(W), .index(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .flush       (flush),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_fill  (frame_fill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int pops  = 0;

    frame_t       sb_q [$];
    bit           m_full = 1'b0;
    int           m_cnt  = 0;
    logic [W-1:0] m_buf [N];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check at negedge against the model, advance model
    task automatic tick(input logic v, input logic [W-1:0] d, input logic f, input logic r);
        frame_t fr;
        in_valid    = v;
        in_data     = d;
        flush       = f;
        frame_ready = r;
        @(negedge clk);
        check("in_ready", {31'd0, in_ready}, {31'd0, !m_full});
        check("frame_valid", {31'd0, frame_valid}, {31'd0, m_full});
        if (m_full) begin
            if (sb_q.size() == 0) begin
                check("sb_empty", 32'd1, 32'd0);
            end else begin
                for (int i = 0; i < N; i++)
                    check($sformatf("slot%0d", i), {24'd0, frame_data[i]}, {24'd0, sb_q[0].d[i]});
                check("frame_fill", {28'd0, frame_fill}, sb_q[0].fill);
                if (r) begin
                    void'(sb_q.pop_front());
                    pops++;
                end
            end
            if (r) begin
                m_full = 1'b0;
                m_cnt  = 0;
            end
        end else begin
            if (v) begin
                m_buf[m_cnt] = d;
                m_cnt++;
            end
            if (m_cnt == N || (f && m_cnt > 0)) begin
                for (int i = 0; i < N; i++)
                    fr.d[i] = (i < m_cnt) ? m_buf[i] : {W{1'b1}};
                fr.fill = m_cnt;
                sb_q.push_back(fr);
                m_full = 1'b1;
                m_cnt  = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] seq_a [8];
        seq_a = '{8'd5, 8'd3, 8'd7, 8'd1, 8'd0, 8'd6, 8'd2, 8'd4};
        rst = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        flush = 1'b0;
        frame_ready = 1'b0;
        #12;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_frame_valid", {31'd0, frame_valid}, 32'd0);
        check("rst_fill", {28'd0, frame_fill}, 32'd0);
        check("rst_slot7", {24'd0, frame_data[7]}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Full frame, held with frame_ready low
        for (int i = 0; i < 8; i++) tick(1'b1, seq_a[i], 1'b0, 1'b0);
        check("a_valid_next", {31'd0, frame_valid}, 32'd1);
        check("a_fill", {28'd0, frame_fill}, 32'd8);
        check("a_slot0", {24'd0, frame_data[0]}, 32'd5);
        check("a_slot7", {24'd0, frame_data[7]}, 32'd4);
        tick(1'b0, 8'd0, 1'b0, 1'b0);
        tick(1'b0, 8'd0, 1'b0, 1'b0);
        tick(1'b0, 8'd0, 1'b0, 1'b1);

        // Partial frame closed by flush, then flush in FULL ignored
        tick(1'b1, 8'd9, 1'b0, 1'b0);
        tick(1'b1, 8'd8, 1'b0, 1'b0);
        tick(1'b1, 8'd7, 1'b0, 1'b0);
        tick(1'b0, 8'd0, 1'b1, 1'b0);
        check("b_fill", {28'd0, frame_fill}, 32'd3);
        check("b_slot2", {24'd0, frame_data[2]}, 32'd7);
        check("b_slot3", {24'd0, frame_data[3]}, 32'd255);
        tick(1'b0, 8'd0, 1'b1, 1'b0);
        tick(1'b0, 8'd0, 1'b0, 1'b1);

        // Flush together with the 5th element, then flush on an empty frame
        for (int i = 1; i <= 4; i++) tick(1'b1, W'(i), 1'b0, 1'b0);
        tick(1'b1, 8'd11, 1'b1, 1'b0);
        check("c_fill", {28'd0, frame_fill}, 32'd5);
        check("c_slot4", {24'd0, frame_data[4]}, 32'd11);
        check("c_slot5", {24'd0, frame_data[5]}, 32'd255);
        tick(1'b0, 8'd0, 1'b0, 1'b1);
        tick(1'b0, 8'd0, 1'b1, 1'b0);
        tick(1'b0, 8'd0, 1'b0, 1'b0);
        tick(1'b0, 8'd0, 1'b0, 1'b0);

        // Flush coinciding with the element that lands in the last slot
        for (int i = 0; i < 7; i++) tick(1'b1, W'(30 + i), 1'b0, 1'b0);
        tick(1'b1, 8'd37, 1'b1, 1'b0);
        check("d_fill", {28'd0, frame_fill}, 32'd8);
        tick(1'b0, 8'd0, 1'b0, 1'b1);

        // Backpressure: input offered while FULL must not be consumed
        for (int i = 0; i < 8; i++) tick(1'b1, W'(20 + i), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) tick(1'b1, 8'd99, 1'b0, 1'b0);
        tick(1'b1, 8'd50, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) tick(1'b1, W'(60 + i), 1'b0, 1'b0);
        check("e_slot0", {24'd0, frame_data[0]}, 32'd60);
        tick(1'b0, 8'd0, 1'b0, 1'b1);

        // Asynchronous reset mid-frame
        for (int i = 0; i < 4; i++) tick(1'b1, W'(70 + i), 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check("ar_frame_valid", {31'd0, frame_valid}, 32'd0);
        check("ar_in_ready", {31'd0, in_ready}, 32'd1);
        check("ar_fill", {28'd0, frame_fill}, 32'd0);
        for (int i = 0; i < N; i++)
            check($sformatf("ar_slot%0d", i), {24'd0, frame_data[i]}, 32'd0);
        rst = 1'b1;
        m_full = 1'b0;
        m_cnt = 0;
        sb_q.delete();
        for (int i = 0; i < 8; i++) tick(1'b1, W'(80 + i), 1'b0, 1'b0);
        tick(1'b0, 8'd0, 1'b0, 1'b1);

        // Continuous traffic with frame_ready high: one frame every 9 cycles
        pops = 0;
        for (int i = 0; i < 27; i++) tick(1'b1, W'($urandom_range(0, 255)), 1'b0, 1'b1);
        check("b2b_frames", pops, 32'd3);
        tick(1'b0, 8'd0, 1'b0, 1'b0);
        tick(1'b0, 8'd0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
